// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_stream block: mode encodings and FSM states.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } fsm_t;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in Fibonacci or Galois form.
// The emitted bit is the current state[0].
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] tap,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state,
  output logic             emit
);

  // Fibonacci shifts the tap parity in at the top; Galois xors the taps in when a one falls out.
  always_comb begin
    next_state = '0;
    if (mode == MODE_FIB) begin
      next_state = {^(state & tap), state[WIDTH-1:1]};
    end else begin
      next_state = (state >> 1) ^ (state[0] ? tap : '0);
    end
  end

  assign emit = state[0];

endmodule

// File: rtl/lfsr_stream.sv
// Parametrised LFSR generator with seed load, all-zero lockup recovery and
// word packing behind a valid/ready handshake with backpressure.
// Optional feature macro: LFSR_PERIOD_CNT_EN enables the sequence period counter;
// without it period and period_valid are tied low.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] tap,
  input  logic [WIDTH-1:0] seed,
  output logic             out,
  output logic [WIDTH-1:0] state,
  output logic [OUT_W-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             stall,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  fsm_t             fsm;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_shift;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] next_safe;
  logic [WIDTH-1:0] seed_safe;
  logic             emit;
  logic             last_bit;
  logic             blocked;
  logic             step;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .state      (state),
    .tap        (tap),
    .mode       (mode),
    .next_state (raw_next),
    .emit       (emit)
  );

  // A step is held off only when it would complete a word that cannot be handed over.
  assign last_bit  = (cnt == CNT_W'(OUT_W - 1));
  assign blocked   = last_bit && word_valid && !word_ready;
  assign step      = en && !load && !blocked;
  assign stall     = en && !rst && !load && blocked;
  assign next_safe = (raw_next == '0) ? WIDTH'(1) : raw_next;
  assign seed_safe = (seed == '0) ? WIDTH'(1) : seed;
  assign out       = state[0];

  // The accumulator shifts the newest bit in at the top so the first bit lands in word[0].
  if (OUT_W == 1) begin : g_acc_single
    assign acc_shift = emit;
  end else begin : g_acc_multi
    assign acc_shift = {emit, acc[OUT_W-1:1]};
  end

  // Core sequencing: LFSR state, lockup guard, packing, handshake and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WIDTH'(1);
      word       <= '0;
      word_valid <= 1'b0;
      lockup     <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      fsm        <= IDLE;
    end else begin
      lockup <= 1'b0;
      if (load) begin
        state      <= seed_safe;
        lockup     <= (seed == '0);
        acc        <= '0;
        cnt        <= '0;
        word_valid <= 1'b0;
        fsm        <= IDLE;
      end else begin
        if (word_valid && word_ready) begin
          word_valid <= 1'b0;
        end
        if (step) begin
          state  <= next_safe;
          lockup <= (raw_next == '0);
          acc    <= acc_shift;
          if (last_bit) begin
            cnt        <= '0;
            word       <= acc_shift;
            word_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        case (fsm)
          IDLE:    if (en) fsm <= RUN;
          RUN:     if (en && blocked) fsm <= STALL;
          STALL:   if (word_ready) fsm <= RUN;
          default: fsm <= IDLE;
        endcase
      end
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] step_inc;

  assign step_inc = (step_cnt == '1) ? step_cnt : step_cnt + WIDTH'(1);

  // Count steps since the last load and latch the count the first time the loaded value returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_state    <= WIDTH'(1);
      step_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (load) begin
      ref_state    <= seed_safe;
      step_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (step) begin
      step_cnt <= step_inc;
      if (!period_valid && next_safe == ref_state) begin
        period       <= step_inc;
        period_valid <= 1'b1;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
